// File: rtl/l1_data_ldst_request_unit_pkg.sv
// Shared encodings for the L1 data load/store request unit: access sizes,
// read/write polarity, FSM state codes and the alignment rule.
package l1_data_ldst_request_unit_pkg;

  localparam logic [1:0] ORDER_BYTE = 2'd0;
  localparam logic [1:0] ORDER_HALF = 2'd1;
  localparam logic [1:0] ORDER_WORD = 2'd2;

  localparam logic RW_LOAD  = 1'b0;
  localparam logic RW_STORE = 1'b1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_OUT   = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  // Reserved size 3 behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] order, input logic [1:0] addr_lo);
    logic mis;
    case (order)
      ORDER_BYTE: mis = 1'b0;
      ORDER_HALF: mis = addr_lo[0];
      default:    mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/l1_data_ldst_request_unit_lane_align.sv
// Combinational byte-lane steering: positions store data into its lanes and
// extracts/extends load data from the returned little-endian word.
module l1_data_ldst_lane_align
  import l1_data_ldst_request_unit_pkg::*;
(
  input  logic [1:0]  st_order,
  input  logic [1:0]  st_addr,
  input  logic [31:0] st_data,
  output logic [31:0] st_lane,
  input  logic [1:0]  ld_order,
  input  logic [1:0]  ld_addr,
  input  logic        ld_signed,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_ext
);

  logic [7:0]  ld_byte_s;
  logic [15:0] ld_half_s;

  // Store lane shifter; lanes not covered by the access stay zero.
  always_comb begin
    st_lane = 32'h0000_0000;
    case (st_order)
      ORDER_BYTE: st_lane = {24'h00_0000, st_data[7:0]} << {st_addr, 3'b000};
      ORDER_HALF: st_lane = st_addr[1] ? {st_data[15:0], 16'h0000} : {16'h0000, st_data[15:0]};
      default:    st_lane = st_data;
    endcase
  end

  // Load lane select followed by zero/sign extension.
  always_comb begin
    ld_ext = 32'h0000_0000;
    case (ld_addr)
      2'd0:    ld_byte_s = ld_word[7:0];
      2'd1:    ld_byte_s = ld_word[15:8];
      2'd2:    ld_byte_s = ld_word[23:16];
      default: ld_byte_s = ld_word[31:24];
    endcase
    if (ld_addr[1]) begin
      ld_half_s = ld_word[31:16];
    end else begin
      ld_half_s = ld_word[15:0];
    end
    case (ld_order)
      ORDER_BYTE: ld_ext = {{24{ld_signed & ld_byte_s[7]}}, ld_byte_s};
      ORDER_HALF: ld_ext = {{16{ld_signed & ld_half_s[15]}}, ld_half_s};
      default:    ld_ext = ld_word;
    endcase
  end

endmodule

// File: rtl/l1_data_ldst_request_unit.sv
// Load/store front end of the L1 data cache: one operation in flight, alignment
// check, cache LDST handshake, flush handling and a single completion to execute.
module l1_data_ldst_request_unit
  import l1_data_ldst_request_unit_pkg::*;
#(
  parameter int P_ADDR_W = 32
)(
  input  logic                iCLOCK,
  input  logic                inRESET,
  input  logic                iREMOVE,
  input  logic                iEXE_REQ,
  output logic                oEXE_BUSY,
  input  logic [1:0]          iEXE_ORDER,
  input  logic                iEXE_RW,
  input  logic                iEXE_SIGNED,
  input  logic [31:0]         iEXE_TID,
  input  logic [1:0]          iEXE_MMUMOD,
  input  logic [31:0]         iEXE_PDT,
  input  logic [P_ADDR_W-1:0] iEXE_ADDR,
  input  logic [P_ADDR_W-1:0] iEXE_DATA,
  output logic                oEXE_VALID,
  output logic                oEXE_PAGEFAULT,
  output logic                oEXE_ALIGN_FAULT,
  output logic [13:0]         oEXE_MMU_FLAGS,
  output logic [P_ADDR_W-1:0] oEXE_DATA,
  output logic                oLDST_REQ,
  input  logic                iLDST_BUSY,
  output logic [1:0]          oLDST_ORDER,
  output logic                oLDST_RW,
  output logic [31:0]         oLDST_TID,
  output logic [1:0]          oLDST_MMUMOD,
  output logic [31:0]         oLDST_PDT,
  output logic [P_ADDR_W-1:0] oLDST_ADDR,
  output logic [P_ADDR_W-1:0] oLDST_DATA,
  input  logic                iLDST_VALID,
  input  logic                iLDST_PAGEFAULT,
  input  logic [13:0]         iLDST_MMU_FLAGS,
  input  logic [P_ADDR_W-1:0] iLDST_DATA
);

  logic [2:0]  state_r, state_nxt_s;
  logic        capture_s, misalign_s, resp_take_s;
  logic [31:0] st_lane_s, ld_ext_s;

  logic [1:0]  order_r;
  logic        rw_r, signed_r;
  logic [31:0] tid_r, pdt_r, addr_r, st_data_r;
  logic [1:0]  mmumod_r;

  logic        exe_pf_r, exe_align_r;
  logic [13:0] exe_flags_r;
  logic [31:0] exe_data_r;

  assign capture_s   = (state_r == ST_IDLE) && iEXE_REQ && !iREMOVE;
  assign resp_take_s = (state_r == ST_WAIT) && iLDST_VALID && !iREMOVE;
  assign misalign_s  = is_misaligned(iEXE_ORDER, iEXE_ADDR[1:0]);

  l1_data_ldst_lane_align u_lane_align (
    .st_order  (iEXE_ORDER),
    .st_addr   (iEXE_ADDR[1:0]),
    .st_data   (iEXE_DATA),
    .st_lane   (st_lane_s),
    .ld_order  (order_r),
    .ld_addr   (addr_r[1:0]),
    .ld_signed (signed_r),
    .ld_word   (iLDST_DATA),
    .ld_ext    (ld_ext_s)
  );

  // Next-state logic; a flush in WAIT drains the outstanding response unless it arrives now.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (capture_s) begin
          state_nxt_s = misalign_s ? ST_OUT : ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (iREMOVE) begin
          state_nxt_s = ST_IDLE;
        end else if (!iLDST_BUSY) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (iLDST_VALID) begin
          state_nxt_s = iREMOVE ? ST_IDLE : ST_OUT;
        end else if (iREMOVE) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (iLDST_VALID) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_OUT:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operation capture; these registers drive the cache request fields directly.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      order_r   <= 2'd0;
      rw_r      <= 1'b0;
      signed_r  <= 1'b0;
      tid_r     <= 32'h0;
      mmumod_r  <= 2'd0;
      pdt_r     <= 32'h0;
      addr_r    <= 32'h0;
      st_data_r <= 32'h0;
    end else if (capture_s) begin
      order_r   <= iEXE_ORDER;
      rw_r      <= iEXE_RW;
      signed_r  <= iEXE_SIGNED;
      tid_r     <= iEXE_TID;
      mmumod_r  <= iEXE_MMUMOD;
      pdt_r     <= iEXE_PDT;
      addr_r    <= iEXE_ADDR;
      st_data_r <= st_lane_s;
    end
  end

  // Completion payload, held until the next completion; data is zero on any fault or store.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      exe_pf_r    <= 1'b0;
      exe_align_r <= 1'b0;
      exe_flags_r <= 14'h0;
      exe_data_r  <= 32'h0;
    end else if (capture_s && misalign_s) begin
      exe_pf_r    <= 1'b0;
      exe_align_r <= 1'b1;
      exe_flags_r <= 14'h0;
      exe_data_r  <= 32'h0;
    end else if (resp_take_s) begin
      exe_pf_r    <= iLDST_PAGEFAULT;
      exe_align_r <= 1'b0;
      exe_flags_r <= iLDST_MMU_FLAGS;
      exe_data_r  <= (iLDST_PAGEFAULT || (rw_r == RW_STORE)) ? 32'h0 : ld_ext_s;
    end
  end

  assign oEXE_BUSY        = (state_r != ST_IDLE);
  assign oEXE_VALID       = (state_r == ST_OUT) && !iREMOVE;
  assign oEXE_PAGEFAULT   = exe_pf_r;
  assign oEXE_ALIGN_FAULT = exe_align_r;
  assign oEXE_MMU_FLAGS   = exe_flags_r;
  assign oEXE_DATA        = exe_data_r;

  assign oLDST_REQ    = (state_r == ST_REQ) && !iREMOVE;
  assign oLDST_ORDER  = order_r;
  assign oLDST_RW     = rw_r;
  assign oLDST_TID    = tid_r;
  assign oLDST_MMUMOD = mmumod_r;
  assign oLDST_PDT    = pdt_r;
  assign oLDST_ADDR   = addr_r;
  assign oLDST_DATA   = st_data_r;

endmodule

// File: tb/tb_l1_data_ldst_request_unit.sv
// Randomized transaction bench: drivers push expected completions into a queue,
// a negedge monitor pops and compares whenever oEXE_VALID is presented.
module tb_l1_data_ldst_request_unit;

  logic        iCLOCK, inRESET, iREMOVE, iEXE_REQ, oEXE_BUSY;
  logic [1:0]  iEXE_ORDER, iEXE_MMUMOD;
  logic        iEXE_RW, iEXE_SIGNED;
  logic [31:0] iEXE_TID, iEXE_PDT, iEXE_ADDR, iEXE_DATA;
  logic        oEXE_VALID, oEXE_PAGEFAULT, oEXE_ALIGN_FAULT;
  logic [13:0] oEXE_MMU_FLAGS;
  logic [31:0] oEXE_DATA;
  logic        oLDST_REQ, iLDST_BUSY, oLDST_RW;
  logic [1:0]  oLDST_ORDER, oLDST_MMUMOD;
  logic [31:0] oLDST_TID, oLDST_PDT, oLDST_ADDR, oLDST_DATA;
  logic        iLDST_VALID, iLDST_PAGEFAULT;
  logic [13:0] iLDST_MMU_FLAGS;
  logic [31:0] iLDST_DATA;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        pf;
    logic        align;
    logic [13:0] flags;
    logic        chk_flags;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  l1_data_ldst_request_unit #(.P_ADDR_W(32)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iREMOVE(iREMOVE),
    .iEXE_REQ(iEXE_REQ), .oEXE_BUSY(oEXE_BUSY), .iEXE_ORDER(iEXE_ORDER),
    .iEXE_RW(iEXE_RW), .iEXE_SIGNED(iEXE_SIGNED), .iEXE_TID(iEXE_TID),
    .iEXE_MMUMOD(iEXE_MMUMOD), .iEXE_PDT(iEXE_PDT), .iEXE_ADDR(iEXE_ADDR),
    .iEXE_DATA(iEXE_DATA), .oEXE_VALID(oEXE_VALID), .oEXE_PAGEFAULT(oEXE_PAGEFAULT),
    .oEXE_ALIGN_FAULT(oEXE_ALIGN_FAULT), .oEXE_MMU_FLAGS(oEXE_MMU_FLAGS),
    .oEXE_DATA(oEXE_DATA), .oLDST_REQ(oLDST_REQ), .iLDST_BUSY(iLDST_BUSY),
    .oLDST_ORDER(oLDST_ORDER), .oLDST_RW(oLDST_RW), .oLDST_TID(oLDST_TID),
    .oLDST_MMUMOD(oLDST_MMUMOD), .oLDST_PDT(oLDST_PDT), .oLDST_ADDR(oLDST_ADDR),
    .oLDST_DATA(oLDST_DATA), .iLDST_VALID(iLDST_VALID), .iLDST_PAGEFAULT(iLDST_PAGEFAULT),
    .iLDST_MMU_FLAGS(iLDST_MMU_FLAGS), .iLDST_DATA(iLDST_DATA)
  );

  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  always @(posedge iCLOCK) cyc <= cyc + 1;

  // ---- reference model: size in bytes, alignment, lane placement, extraction ----
  function automatic int sz_f(input logic [1:0] o);
    return (o == 2'd0) ? 1 : (o == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic mis_f(input logic [1:0] o, input logic [31:0] a);
    return (a % 32'(sz_f(o))) != 32'd0;
  endfunction

  function automatic logic [31:0] lane_f(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d);
    int sz;
    logic [31:0] mask;
    sz = sz_f(o);
    if (sz == 4) return d;
    mask = (32'd1 << (8 * sz)) - 32'd1;
    return (d & mask) << (8 * (a % 32'd4));
  endfunction

  function automatic logic [31:0] load_f(input logic [1:0] o, input logic [31:0] a,
                                         input logic sgn, input logic [31:0] w);
    int sz;
    logic [31:0] mask, v;
    sz = sz_f(o);
    if (sz == 4) return w;
    mask = (32'd1 << (8 * sz)) - 32'd1;
    v = (w >> (8 * (a % 32'd4))) & mask;
    if (sgn && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge iCLOCK);
    #2;
  endtask

  // Completion monitor.
  always @(negedge iCLOCK) begin
    if (inRESET && oEXE_VALID) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got oEXE_VALID=1 expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("valid_cycle", 32'(cyc), 32'(e.cyc));
        chk("exe_data", oEXE_DATA, e.data);
        chk("exe_pagefault", 32'(oEXE_PAGEFAULT), 32'(e.pf));
        chk("exe_align_fault", 32'(oEXE_ALIGN_FAULT), 32'(e.align));
        if (e.chk_flags) chk("exe_mmu_flags", 32'(oEXE_MMU_FLAGS), 32'(e.flags));
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(oEXE_BUSY), 32'd0);
    chk({tag, "_valid"}, 32'(oEXE_VALID), 32'd0);
    chk({tag, "_pf"}, 32'(oEXE_PAGEFAULT), 32'd0);
    chk({tag, "_align"}, 32'(oEXE_ALIGN_FAULT), 32'd0);
    chk({tag, "_flags"}, 32'(oEXE_MMU_FLAGS), 32'd0);
    chk({tag, "_exe_data"}, oEXE_DATA, 32'd0);
    chk({tag, "_ldst_req"}, 32'(oLDST_REQ), 32'd0);
    chk({tag, "_ldst_order"}, 32'(oLDST_ORDER), 32'd0);
    chk({tag, "_ldst_rw"}, 32'(oLDST_RW), 32'd0);
    chk({tag, "_ldst_tid"}, oLDST_TID, 32'd0);
    chk({tag, "_ldst_mmumod"}, 32'(oLDST_MMUMOD), 32'd0);
    chk({tag, "_ldst_pdt"}, oLDST_PDT, 32'd0);
    chk({tag, "_ldst_addr"}, oLDST_ADDR, 32'd0);
    chk({tag, "_ldst_data"}, oLDST_DATA, 32'd0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!oEXE_BUSY) break;
      step();
    end
    chk("idle_wait", 32'(oEXE_BUSY), 32'd0);
  endtask

  task automatic chk_req(input logic [1:0] o, input logic rw, input logic [31:0] a,
                         input logic [31:0] lane, input logic [31:0] tid,
                         input logic [31:0] pdt, input logic [1:0] mm);
    chk("ldst_req", 32'(oLDST_REQ), 32'd1);
    chk("exe_busy_in_req", 32'(oEXE_BUSY), 32'd1);
    chk("ldst_order", 32'(oLDST_ORDER), 32'(o));
    chk("ldst_rw", 32'(oLDST_RW), 32'(rw));
    chk("ldst_addr", oLDST_ADDR, a);
    chk("ldst_data", oLDST_DATA, lane);
    chk("ldst_tid", oLDST_TID, tid);
    chk("ldst_pdt", oLDST_PDT, pdt);
    chk("ldst_mmumod", 32'(oLDST_MMUMOD), 32'(mm));
  endtask

  // One operation. rmode: 0 normal, 1 flush in REQ, 2 flush in WAIT then late response,
  // 3 flush during OUT, 4 flush together with the response.
  task automatic do_op(input logic [1:0] o, input logic rw, input logic sgn,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] resp,
                       input logic pf, input int busy_n, input int dly, input int rmode);
    logic [31:0] tid, pdt, lane;
    logic [1:0]  mm;
    logic [13:0] flags;
    exp_t        e;
    tid = $urandom; pdt = $urandom; mm = 2'($urandom); flags = 14'($urandom);
    lane = lane_f(o, a, d);
    wait_idle();
    iEXE_REQ = 1'b1; iEXE_ORDER = o; iEXE_RW = rw; iEXE_SIGNED = sgn;
    iEXE_TID = tid; iEXE_PDT = pdt; iEXE_MMUMOD = mm; iEXE_ADDR = a; iEXE_DATA = d;
    if (mis_f(o, a)) begin
      e.cyc = cyc + 1; e.data = 32'h0; e.pf = 1'b0; e.align = 1'b1;
      e.flags = 14'h0; e.chk_flags = 1'b0;
      exp_q.push_back(e);
      step();
      iEXE_REQ = 1'b0; iLDST_VALID = 1'b1; iLDST_DATA = $urandom;
      #1 chk("no_req_on_align", 32'(oLDST_REQ), 32'd0);
      step();
      iLDST_VALID = 1'b0;
      return;
    end
    step();
    iEXE_REQ = 1'b0; iEXE_ADDR = $urandom; iEXE_DATA = $urandom; iEXE_TID = $urandom;
    if (rmode == 1) begin
      iREMOVE = 1'b1;
      #1 chk("req_masked_by_remove", 32'(oLDST_REQ), 32'd0);
      step();
      iREMOVE = 1'b0;
      chk("idle_after_req_flush", 32'(oEXE_BUSY), 32'd0);
      return;
    end
    for (int i = 0; i < busy_n; i++) begin
      iLDST_BUSY = 1'b1; iLDST_VALID = 1'($urandom);
      #1 chk_req(o, rw, a, lane, tid, pdt, mm);
      step();
    end
    iLDST_BUSY = 1'b0; iLDST_VALID = 1'b0;
    #1 chk_req(o, rw, a, lane, tid, pdt, mm);
    step();
    if (rmode == 4) begin
      iREMOVE = 1'b1; iLDST_VALID = 1'b1; iLDST_DATA = resp;
      step();
      iREMOVE = 1'b0; iLDST_VALID = 1'b0;
      chk("idle_after_flush_with_resp", 32'(oEXE_BUSY), 32'd0);
      return;
    end
    if (rmode == 2) begin
      iREMOVE = 1'b1;
      step();
      iREMOVE = 1'b0;
      for (int i = 0; i < dly; i++) begin
        chk("busy_while_draining", 32'(oEXE_BUSY), 32'd1);
        step();
      end
      iLDST_VALID = 1'b1; iLDST_DATA = resp;
      step();
      iLDST_VALID = 1'b0;
      chk("idle_after_drain", 32'(oEXE_BUSY), 32'd0);
      return;
    end
    for (int i = 0; i < dly; i++) step();
    iLDST_VALID = 1'b1; iLDST_DATA = resp; iLDST_PAGEFAULT = pf; iLDST_MMU_FLAGS = flags;
    if (rmode != 3) begin
      e.cyc = cyc + 1;
      e.data = (pf || rw) ? 32'h0 : load_f(o, a, sgn, resp);
      e.pf = pf; e.align = 1'b0; e.flags = flags; e.chk_flags = 1'b1;
      exp_q.push_back(e);
    end
    step();
    iLDST_VALID = 1'b0; iLDST_PAGEFAULT = 1'b0;
    if (rmode == 3) begin
      iREMOVE = 1'b1;
      step();
      iREMOVE = 1'b0;
    end
  endtask

  initial begin
    inRESET = 1'b0; iREMOVE = 1'b0; iEXE_REQ = 1'b0; iEXE_ORDER = 2'd0; iEXE_RW = 1'b0;
    iEXE_SIGNED = 1'b0; iEXE_TID = 32'h0; iEXE_MMUMOD = 2'd0; iEXE_PDT = 32'h0;
    iEXE_ADDR = 32'h0; iEXE_DATA = 32'h0; iLDST_BUSY = 1'b0; iLDST_VALID = 1'b0;
    iLDST_PAGEFAULT = 1'b0; iLDST_MMU_FLAGS = 14'h0; iLDST_DATA = 32'h0;
    repeat (3) step();
    chk_all_zero("reset");
    inRESET = 1'b1;
    step();

    // directed cases
    do_op(2'd2, 1'b0, 1'b0, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, 0, 0);
    do_op(2'd0, 1'b0, 1'b1, 32'h0000_2003, 32'h0, 32'h80FF_0000, 1'b0, 0, 0, 0);
    do_op(2'd0, 1'b0, 1'b0, 32'h0000_2003, 32'h0, 32'h80FF_0000, 1'b0, 0, 1, 0);
    do_op(2'd1, 1'b1, 1'b0, 32'h0000_3002, 32'h0000_1234, 32'h0, 1'b0, 4, 0, 0);
    do_op(2'd2, 1'b0, 1'b0, 32'h0000_4002, 32'h0, 32'h0, 1'b0, 0, 0, 0);
    do_op(2'd2, 1'b0, 1'b0, 32'h0000_5000, 32'h0, 32'h1111_2222, 1'b0, 0, 5, 2);
    do_op(2'd1, 1'b0, 1'b1, 32'h0000_5002, 32'h0, 32'h8001_7FFF, 1'b0, 0, 0, 0);
    do_op(2'd2, 1'b0, 1'b0, 32'h0000_6000, 32'h0, 32'h5555_AAAA, 1'b1, 1, 0, 0);
    do_op(2'd3, 1'b0, 1'b1, 32'h0000_6001, 32'h0, 32'h0, 1'b0, 0, 0, 0);
    do_op(2'd0, 1'b1, 1'b0, 32'h0000_7001, 32'hABCD_EF5A, 32'h0, 1'b0, 0, 0, 1);
    do_op(2'd2, 1'b0, 1'b0, 32'h0000_8000, 32'h0, 32'h1234_5678, 1'b0, 0, 1, 3);
    do_op(2'd2, 1'b0, 1'b0, 32'h0000_9000, 32'h0, 32'h1234_5678, 1'b0, 0, 0, 4);

    // randomized operations
    for (int n = 0; n < 150; n++) begin
      logic [1:0]  o;
      logic [31:0] a;
      int          r, rm;
      o = 2'($urandom);
      a = $urandom;
      if (($urandom % 4) != 0) a = a - (a % 32'(sz_f(o)));
      r = int'($urandom % 10);
      rm = (r < 6) ? 0 : r - 5;
      do_op(o, 1'($urandom), 1'($urandom), a, $urandom, $urandom,
            (($urandom % 8) == 0), int'($urandom % 3), int'($urandom % 3), rm);
    end

    // asynchronous reset while waiting on the cache
    wait_idle();
    iEXE_REQ = 1'b1; iEXE_ORDER = 2'd2; iEXE_RW = 1'b1; iEXE_ADDR = 32'hCAFE_0008;
    iEXE_DATA = 32'h0BAD_F00D; iEXE_TID = 32'h77; iEXE_PDT = 32'h1000; iEXE_MMUMOD = 2'd3;
    step();
    iEXE_REQ = 1'b0;
    step();
    chk("in_wait_before_reset", 32'(oEXE_BUSY), 32'd1);
    inRESET = 1'b0;
    #1 chk_all_zero("midwait_reset");
    step();
    inRESET = 1'b1;
    step();
    do_op(2'd2, 1'b0, 1'b0, 32'h0000_A000, 32'h0, 32'hFEED_FACE, 1'b0, 0, 0, 0);
    wait_idle();
    repeat (3) step();
    chk("pending_completions", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l1_data_ldst_request_unit.md
Name: l1_data_ldst_request_unit

Overview:
- Load/store front end sitting directly upstream of the L1 data cache.
- Accepts one memory operation at a time from the execute stage and checks alignment.
- Positions store data into byte lanes, then issues the request on the cache's LDST handshake.
- Extracts and sign/zero-extends load data from the returned 32-bit word and returns a single completion (or fault) to execute.

Parameters:
- P_ADDR_W, 32, address/data width; only 32 is supported.

Ports:
- iCLOCK  in  1  system clock
- inRESET  in  1  asynchronous active-low reset
- iREMOVE  in  1  pipeline flush; abort the current operation
- iEXE_REQ  in  1  operation request from execute
- oEXE_BUSY  out  1  unit cannot accept a request this cycle
- iEXE_ORDER  in  2  access size: 0=byte, 1=half, 2=word, 3=reserved (treated as word)
- iEXE_RW  in  1  0=load, 1=store
- iEXE_SIGNED  in  1  load sign-extend enable
- iEXE_TID  in  32  task ID
- iEXE_MMUMOD  in  2  MMU mode
- iEXE_PDT  in  32  page directory table base
- iEXE_ADDR  in  32  byte address
- iEXE_DATA  in  32  store data, right-justified
- oEXE_VALID  out  1  completion pulse
- oEXE_PAGEFAULT  out  1  completion carries a page fault
- oEXE_ALIGN_FAULT  out  1  completion carries an alignment fault
- oEXE_MMU_FLAGS  out  14  MMU flags of the access
- oEXE_DATA  out  32  extended load data (0 for stores)
- oLDST_REQ  out  1  request to cache
- iLDST_BUSY  in  1  cache busy
- oLDST_ORDER  out  2  registered access size
- oLDST_RW  out  1  registered rw (0=load, 1=store)
- oLDST_TID  out  32  registered task ID
- oLDST_MMUMOD  out  2  registered MMU mode
- oLDST_PDT  out  32  registered page directory table base
- oLDST_ADDR  out  32  registered address
- oLDST_DATA  out  32  lane-positioned store data
- iLDST_VALID  in  1  cache response
- iLDST_PAGEFAULT  in  1  response page fault
- iLDST_MMU_FLAGS  in  14  response MMU flags
- iLDST_DATA  in  32  response word

Behaviour:
- **Reset.** Reset is asynchronous, active-low. All registers clear and state=IDLE. All outputs are 0; oEXE_BUSY is 0.
- **States.** IDLE, REQ, WAIT, OUT, DRAIN (3-bit encoding). oEXE_BUSY = (state!=IDLE).
- **IDLE.**
  - iEXE_REQ && !iREMOVE: capture all iEXE_* fields into registers.
  - Misaligned access goes to OUT with the align-fault flag set, and no cache request is made. Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - Otherwise go to REQ.
- **Store lane positioning** (little-endian lanes, computed at capture):
  - byte: data[7:0] << 8*addr[1:0]
  - half: data[15:0] << 16*addr[1]
  - word: unchanged
  - Unused lanes are 0.
- **REQ.**
  - oLDST_REQ = !iREMOVE. All oLDST_* fields come from registers.
  - !iLDST_BUSY && !iREMOVE: go to WAIT.
  - iREMOVE: go to IDLE.
  - The request holds stable while iLDST_BUSY=1.
- **WAIT.**
  - iLDST_VALID: latch data, pagefault and flags, then go to OUT.
  - iREMOVE without a simultaneous iLDST_VALID: go to DRAIN.
  - iREMOVE with a simultaneous iLDST_VALID: go to IDLE with the response discarded.
- **DRAIN.** Wait for iLDST_VALID, discard it, go to IDLE. This guarantees a stale cache response never completes a later operation.
- **OUT.** Lasts exactly one cycle.
  - oEXE_VALID = !iREMOVE; then go to IDLE.
  - Faults are reported in OUT; oEXE_DATA is 0 whenever any fault is set.
  - oEXE_DATA for loads: select lane by addr (byte addr[1:0], half addr[1]), then zero- or sign-extend per iEXE_SIGNED. Word loads pass through.
- **Completion outputs.** oEXE_* outputs other than VALID are held between completions. They are meaningful only when oEXE_VALID=1.
- **Latency.** Request accepted at cycle N → oLDST_REQ at N+1. With no busy and a cache response at N+2, oEXE_VALID occurs at N+3. An alignment fault gives oEXE_VALID at N+1.
- **Backpressure.** A new iEXE_REQ arriving while busy is ignored; execute must hold it until oEXE_BUSY=0. Back-to-back requests are accepted in the cycle after OUT.
- **Unsolicited responses.** An iLDST_VALID in IDLE/REQ/OUT is ignored.

Decomposition:
- Shared package: access-size constants (BYTE/HALF/WORD), RW encoding constants, state encodings.
- One natural sub-module, l1_data_ldst_lane_align: purely combinational; contains both the store lane shifter and the load extractor/extender. The FSM and registers stay in the top.

Test Plan:
- Word load addr 0x0000_1004, cache returns 0xDEADBEEF one cycle after REQ → oEXE_VALID 3 cycles after accept, oEXE_DATA=0xDEADBEEF, faults 0.
- Signed byte load addr 0x..03, response 0x80FF_0000 → oEXE_DATA=0xFFFFFF80; unsigned → 0x00000080.
- Half store data 0x0000_1234 addr 0x..02 → oLDST_DATA=0x1234_0000, oLDST_RW=1; iLDST_BUSY held high 4 cycles → request stable, no state change.
- Word load addr 0x..02 → oEXE_VALID next cycle with oEXE_ALIGN_FAULT=1, oLDST_REQ never asserted.
- iREMOVE in WAIT, response arrives 5 cycles later → no oEXE_VALID, oEXE_BUSY=1 until the response, then a new request accepted normally.
- Cache response with iLDST_PAGEFAULT=1 → oEXE_PAGEFAULT=1, oEXE_DATA=0; inRESET asserted mid-WAIT → all outputs 0 immediately.
